// File: rtl/execute_stage.sv
// EX stage of the RV32 pipeline: operand forwarding, ALU, branch/jump redirect
// and the EX/MEM pipeline register that feeds the memory stage.
module execute_stage #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   PCE,
    input  logic [WIDTH-1:0]   PCPlus4E,
    input  logic [WIDTH-1:0]   RD1E,
    input  logic [WIDTH-1:0]   RD2E,
    input  logic [WIDTH-1:0]   ImmExtE,
    input  logic [REGADDR-1:0] RdE,
    input  logic               RegWriteE,
    input  logic [1:0]         ResultSrcE,
    input  logic               MemWriteE,
    input  logic               JumpE,
    input  logic               BranchE,
    input  logic [2:0]         ALUControlE,
    input  logic               ALUSrcE,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [WIDTH-1:0]   ResultW,
    output logic               PCSrcE,
    output logic [WIDTH-1:0]   PCTargetE,
    output logic [WIDTH-1:0]   ALUResultM,
    output logic [WIDTH-1:0]   WriteDataM,
    output logic [REGADDR-1:0] RdM,
    output logic [WIDTH-1:0]   PCPlus4M,
    output logic               RegWriteM,
    output logic [1:0]         ResultSrcM,
    output logic               MemWriteM
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] srcAE;
    logic [WIDTH-1:0] writeDataE;
    logic [WIDTH-1:0] srcBE;
    logic [WIDTH-1:0] aluResultE;
    logic             zeroE;

    // Select 11 is unused by the hazard unit and falls back to the ID/EX value.
    always_comb begin
        srcAE = RD1E;
        case (ForwardAE)
            2'b01:   srcAE = ResultW;
            2'b10:   srcAE = ALUResultM;
            default: srcAE = RD1E;
        endcase
    end

    always_comb begin
        writeDataE = RD2E;
        case (ForwardBE)
            2'b01:   writeDataE = ResultW;
            2'b10:   writeDataE = ALUResultM;
            default: writeDataE = RD2E;
        endcase
    end

    assign srcBE = ALUSrcE ? ImmExtE : writeDataE;

    always_comb begin
        aluResultE = '0;
        case (ALUControlE)
            3'b000:  aluResultE = srcAE + srcBE;
            3'b001:  aluResultE = srcAE - srcBE;
            3'b010:  aluResultE = srcAE & srcBE;
            3'b011:  aluResultE = srcAE | srcBE;
            3'b100:  aluResultE = srcAE ^ srcBE;
            3'b101:  aluResultE = {{(WIDTH-1){1'b0}}, ($signed(srcAE) < $signed(srcBE))};
            3'b110:  aluResultE = srcAE << srcBE[SHW-1:0];
            default: aluResultE = srcAE >> srcBE[SHW-1:0];
        endcase
    end

    assign zeroE     = (aluResultE == '0);
    assign PCSrcE    = JumpE | (BranchE & zeroE);
    assign PCTargetE = PCE + ImmExtE;

    // Writes to x0 are dropped here so the hazard unit never forwards from x0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            RdM        <= '0;
            PCPlus4M   <= '0;
            RegWriteM  <= 1'b0;
            ResultSrcM <= '0;
            MemWriteM  <= 1'b0;
        end else begin
            ALUResultM <= aluResultE;
            WriteDataM <= writeDataE;
            RdM        <= RdE;
            PCPlus4M   <= PCPlus4E;
            RegWriteM  <= RegWriteE & (RdE != '0);
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= MemWriteE;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed plan items plus random traffic, checked
// against a behavioural model through an expected-value queue.
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic [31:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE, ResultW;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlE;
    logic        PCSrcE;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;

    execute_stage #(.WIDTH(32), .REGADDR(5)) dut (
        .clk(clk), .reset(reset),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM)
    );

    typedef struct {
        logic [31:0] pc, rd1, rd2, imm, resW;
        logic [4:0]  rd;
        logic        regWrite, memWrite, jump, branch, aluSrc;
        logic [1:0]  resSrc, fa, fb;
        logic [2:0]  op;
    } stim_t;

    typedef struct {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rs;
    } expm_t;

    expm_t       expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] lastAlu  = '0;   // what ALUResultM should hold right now

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd6:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{pc: 32'h100, rd1: '0, rd2: '0, imm: '0, resW: '0, rd: '0, regWrite: 1'b0,
              memWrite: 1'b0, jump: 1'b0, branch: 1'b0, aluSrc: 1'b0, resSrc: '0,
              fa: '0, fb: '0, op: '0};
        return s;
    endfunction

    task automatic checkAllZero(input string tag);
        check({tag, "_ALUResultM"}, ALUResultM, 32'd0);
        check({tag, "_WriteDataM"}, WriteDataM, 32'd0);
        check({tag, "_RdM"}, {27'd0, RdM}, 32'd0);
        check({tag, "_PCPlus4M"}, PCPlus4M, 32'd0);
        check({tag, "_RegWriteM"}, {31'd0, RegWriteM}, 32'd0);
        check({tag, "_ResultSrcM"}, {30'd0, ResultSrcM}, 32'd0);
        check({tag, "_MemWriteM"}, {31'd0, MemWriteM}, 32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic issue(input stim_t s);
        logic [31:0] a, rs2, b, alu;
        expm_t e;
        @(negedge clk);
        PCE = s.pc; PCPlus4E = s.pc + 32'd4; RD1E = s.rd1; RD2E = s.rd2;
        ImmExtE = s.imm; ResultW = s.resW; RdE = s.rd; RegWriteE = s.regWrite;
        ResultSrcE = s.resSrc; MemWriteE = s.memWrite; JumpE = s.jump; BranchE = s.branch;
        ALUControlE = s.op; ALUSrcE = s.aluSrc; ForwardAE = s.fa; ForwardBE = s.fb;
        a   = (s.fa == 2'd1) ? s.resW : (s.fa == 2'd2) ? lastAlu : s.rd1;
        rs2 = (s.fb == 2'd1) ? s.resW : (s.fb == 2'd2) ? lastAlu : s.rd2;
        b   = s.aluSrc ? s.imm : rs2;
        alu = aluModel(s.op, a, b);
        #1;
        check("PCSrcE", {31'd0, PCSrcE}, {31'd0, s.jump | (s.branch & (alu == 32'd0))});
        check("PCTargetE", PCTargetE, s.pc + s.imm);
        e.alu = alu; e.wd = rs2; e.pc4 = s.pc + 32'd4; e.rd = s.rd;
        e.rw = s.regWrite && (s.rd != 5'd0); e.mw = s.memWrite; e.rs = s.resSrc;
        expQ.push_back(e);
        lastAlu = alu;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (reset && expQ.size() > 0) begin
            expm_t e;
            e = expQ.pop_front();
            check("ALUResultM", ALUResultM, e.alu);
            check("WriteDataM", WriteDataM, e.wd);
            check("RdM", {27'd0, RdM}, {27'd0, e.rd});
            check("PCPlus4M", PCPlus4M, e.pc4);
            check("RegWriteM", {31'd0, RegWriteM}, {31'd0, e.rw});
            check("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, e.rs});
            check("MemWriteM", {31'd0, MemWriteM}, {31'd0, e.mw});
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        logic [2:0] sweepOps[5];
        sweepOps = '{3'd1, 3'd5, 3'd6, 3'd7, 3'd4};

        // Reset held with nonzero inputs while the clock runs.
        reset = 1'b0;
        PCE = 32'h200; PCPlus4E = 32'h204; RD1E = 32'h55; RD2E = 32'h66; ImmExtE = 32'h8;
        ResultW = 32'h77; RdE = 5'd3; RegWriteE = 1'b1; ResultSrcE = 2'b01; MemWriteE = 1'b1;
        JumpE = 1'b0; BranchE = 1'b0; ALUControlE = 3'd0; ALUSrcE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(posedge clk); #2;
        reset = 1'b1;

        // 5 + 3 = 8 on the first edge after release.
        s = nop(); s.rd1 = 32'd5; s.rd2 = 32'd3; issue(s);

        // ALU sweep with SrcB = 4 from the immediate.
        foreach (sweepOps[i]) begin
            s = nop(); s.rd1 = 32'hFFFF_FFF0; s.imm = 32'd4; s.aluSrc = 1'b1; s.op = sweepOps[i];
            issue(s);
        end

        // Forwarding chain: 7+1, then ALUResultM+2, then 1+ResultW.
        s = nop(); s.rd1 = 32'd7; s.rd2 = 32'd1; issue(s);
        s = nop(); s.fa = 2'b10; s.rd1 = 32'd0; s.rd2 = 32'd2; issue(s);
        s = nop(); s.fb = 2'b01; s.resW = 32'h20; s.rd1 = 32'd1; issue(s);

        // Branch / jump redirect.
        s = nop(); s.imm = 32'h40; s.branch = 1'b1; s.op = 3'd1; s.rd1 = 32'h9; s.rd2 = 32'h9; issue(s);
        s.rd2 = 32'hA; issue(s);
        s.branch = 1'b0; s.jump = 1'b1; issue(s);

        // x0 write suppression and the store path.
        s = nop(); s.rd = 5'd0; s.regWrite = 1'b1; s.rd1 = 32'h3; issue(s);
        s = nop(); s.memWrite = 1'b1; s.aluSrc = 1'b1; s.imm = 32'd8; s.rd2 = 32'hDEAD;
        s.rd1 = 32'h1000; s.rd = 5'd4; issue(s);

        // Mid-stream asynchronous reset between edges.
        s = nop(); s.rd = 5'd5; s.regWrite = 1'b1; s.rd1 = 32'h11; s.rd2 = 32'h22; issue(s);
        @(posedge clk); #3;
        check("pre_reset_RegWriteM", {31'd0, RegWriteM}, 32'd1);
        reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        lastAlu = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_held");
        @(posedge clk); #2;
        reset = 1'b1;

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            s.pc       = $urandom & 32'hFFFF_FFFC;
            s.rd1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            s.rd2      = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
            s.imm      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            s.resW     = $urandom;
            s.rd       = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.regWrite = 1'($urandom_range(0, 1));
            s.memWrite = 1'($urandom_range(0, 1));
            s.jump     = ($urandom_range(0, 5) == 0);
            s.branch   = 1'($urandom_range(0, 1));
            s.aluSrc   = 1'($urandom_range(0, 1));
            s.resSrc   = 2'($urandom_range(0, 3));
            s.fa       = 2'($urandom_range(0, 3));
            s.fb       = 2'($urandom_range(0, 3));
            s.op       = 3'($urandom_range(0, 7));
            issue(s);
        end

        @(posedge clk); #2;
        check("queue_drain", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
